skewed_systolic_array: RTL and testbench
========================================

SKEWED_SYSTOLIC_ARRAY -- requirements
Module: skewed_systolic_array

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning array rows (A lanes).
REQ-002 SHALL have parameter COLS, default 4, meaning array columns (B lanes).
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning signed operand width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, meaning signed accumulator width; must be >= 2*DATA_WIDTH.
REQ-005 SHALL have parameter KLEN_WIDTH, default 8, meaning width of k_len.
REQ-006 SHALL have one clock; reset is asynchronous and active-high, with ports named clk and rst.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst  input  1  asynchronous active-high reset.
REQ-009 start  input  1  begin a tile; sampled only in IDLE.
REQ-010 k_len  input  KLEN_WIDTH  inner-product length; latched on accepted start.
REQ-011 in_valid / in_ready  input / output  1  input beat handshake.
REQ-012 a_in  input  ROWS*DATA_WIDTH  lane r = A[r][k], at bits [(ROWS-r)*DW-1 : (ROWS-r-1)*DW].
REQ-013 b_in  input  COLS*DATA_WIDTH  lane c = B[k][c], same MSB-first packing.
REQ-014 out_valid / out_ready  output / input  1  result row handshake.
REQ-015 out_row  output  clog2(ROWS)  index of the row on out_data.
REQ-016 out_data  output  COLS*ACC_WIDTH  C[out_row][c], lane c MSB-first.
REQ-017 busy  output  1  high whenever state != IDLE.
REQ-018 done  output  1  one-cycle pulse on the DRAIN->IDLE transition.

Function
REQ-019 SHALL implement an output-stationary FSM with states IDLE, LOAD, FLUSH, DRAIN.
REQ-020 IDLE, start=1: clear all accumulators and skew registers, latch k_len, go to LOAD (or DRAIN if k_len==0); start in other states ignored.
REQ-021 LOAD: in_ready=1; beat accepted on in_valid&in_ready; after the k_len-th accepted beat, go to FLUSH.
REQ-022 Cycles without an accepted beat (bubbles) SHALL inject zero operands; results are unaffected by bubble count or placement.
REQ-023 A lane r SHALL be delayed r cycles, and B lane c delayed c cycles, by internal skew registers; operands then shift one PE east (A) / south (B) per cycle.
REQ-024 A beat accepted at edge t SHALL update PE(r,c)'s accumulator at edge t+1+r+c.
REQ-025 FLUSH SHALL last exactly ROWS+COLS-1 cycles, then go to DRAIN; out_valid rises ROWS+COLS-1 cycles after the last accepted beat.
REQ-026 Arithmetic SHALL be signed two's complement: product 2*DW bits, sign-extended to ACC_WIDTH, summed modulo 2^ACC_WIDTH (wrap, no saturation).
REQ-027 DRAIN: out_valid=1 and out_row=row counter starting at 0; advance on out_valid&out_ready; after row ROWS-1 is accepted, go to IDLE with done=1 for one cycle.
REQ-028 While out_valid=1 and out_ready=0, out_row and out_data SHALL hold stable.
REQ-029 Outside DRAIN, out_data SHALL be 0 and out_valid=0; outside LOAD, in_ready=0.

Reset
REQ-030 rst SHALL force IDLE asynchronously, including mid-operation, and clear all accumulators, skew and pipeline registers, and counters.
REQ-031 During reset, in_ready, out_valid, busy, done, out_row, and out_data SHALL all be 0.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the lane-slice width constants.
REQ-033 A sub-module mac_pe SHALL hold one MAC cell: registered east/south pass-through, accumulator, synchronous clear, and enable.
REQ-034 skewed_systolic_array SHALL instantiate ROWS*COLS mac_pe cells plus the skew registers, FSM, and counters.

Verification (ROWS=COLS=2, DW=8, ACC=32 unless noted)
REQ-035 Identity: k_len=2, A=I, B=[[1,2],[3,4]] -> row0 (1,2), row1 (3,4); out_valid 3 cycles after the last beat; done pulses once.
REQ-036 Signed: k_len=1, a=(-3,2), b=(4,-5) -> row0 (-12,15), row1 (8,-10).
REQ-037 Bubbles: REQ-035 stimulus with in_valid low 3 cycles between beats -> identical results.
REQ-038 Backpressure: out_ready low 4 cycles on row0 -> out_row=0 and out_data stable; row1 follows the first out_ready=1.
REQ-039 Reset/edge: rst mid-LOAD -> all outputs 0, busy=0; a restart with k_len=0 -> rows (0,0),(0,0), then done.
REQ-040 Wrap (ACC_WIDTH=16): k_len=2, all operands -128 -> every element -32768.

Source files
------------

// File: rtl/skewed_systolic_array_pkg.sv
// Shared definitions for the skewed output-stationary systolic array:
// FSM state encoding, default lane widths and the MSB-first lane slicing helper.
package skewed_systolic_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int DEFAULT_ROWS       = 4;
    localparam int DEFAULT_COLS       = 4;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ACC_WIDTH  = 32;
    localparam int DEFAULT_KLEN_WIDTH = 8;

    // Lane 0 sits in the most significant slice of a packed bus.
    function automatic int lane_lo(input int lane, input int lanes, input int width);
        return (lanes - lane - 1) * width;
    endfunction

endpackage

// File: rtl/skewed_systolic_array_mac_pe.sv
// One MAC cell: signed multiply-accumulate with registered east (A) and
// south (B) operand forwarding, synchronous clear and enable.
module mac_pe
    import skewed_systolic_array_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    logic [DATA_WIDTH-1:0]       a_q, a_d;
    logic [DATA_WIDTH-1:0]       b_q, b_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] a_ext, b_ext, prod;

    // Multiplying at accumulator width gives the sign-extended product modulo 2^ACC_WIDTH.
    assign a_ext = ACC_WIDTH'($signed(a_in));
    assign b_ext = ACC_WIDTH'($signed(b_in));
    assign prod  = a_ext * b_ext;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clear) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;
    assign acc   = acc_q;

endmodule

// File: rtl/skewed_systolic_array.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with input skew
// registers, a LOAD/FLUSH/DRAIN controller and a row-at-a-time result port.
module skewed_systolic_array
    import skewed_systolic_array_pkg::*;
#(
    parameter int ROWS       = DEFAULT_ROWS,
    parameter int COLS       = DEFAULT_COLS,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int KLEN_WIDTH = DEFAULT_KLEN_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KLEN_WIDTH-1:0]      k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_in,
    input  logic [COLS*DATA_WIDTH-1:0] b_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(ROWS)-1:0]    out_row,
    output logic [COLS*ACC_WIDTH-1:0]  out_data,
    output logic                       busy,
    output logic                       done
);

    localparam int ROW_W      = $clog2(ROWS);
    localparam int FLUSH_W    = $clog2(ROWS + COLS);
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    state_e                state_q, state_d;
    logic [KLEN_WIDTH-1:0] klen_q, klen_d;
    logic [KLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
    logic                  done_q, done_d;

    logic clear;
    logic accept;
    logic pe_en;
    logic last_beat;
    logic last_row;

    logic [DATA_WIDTH-1:0] a_bus [ROWS][COLS+1];
    logic [DATA_WIDTH-1:0] b_bus [ROWS+1][COLS];
    logic [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];

    assign clear     = (state_q == ST_IDLE) && start;
    assign accept    = (state_q == ST_LOAD) && in_valid;
    assign pe_en     = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign last_beat = accept && (beat_cnt_q == klen_q - KLEN_WIDTH'(1));
    assign last_row  = (row_cnt_q == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (k_len == '0) ? ST_DRAIN : ST_LOAD;
            ST_LOAD:  if (last_beat) state_d = ST_FLUSH;
            ST_FLUSH: if (flush_cnt_q == FLUSH_W'(FLUSH_LAST)) state_d = ST_DRAIN;
            ST_DRAIN: if (out_ready && last_row) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_DRAIN);
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        out_row   = (state_q == ST_DRAIN) ? row_cnt_q : '0;
        out_data  = '0;
        if (state_q == ST_DRAIN) begin
            for (int r = 0; r < ROWS; r++) begin
                if (row_cnt_q == ROW_W'(r)) begin
                    for (int c = 0; c < COLS; c++) begin
                        out_data[lane_lo(c, COLS, ACC_WIDTH) +: ACC_WIDTH] = acc_w[r][c];
                    end
                end
            end
        end
    end

    always_comb begin
        klen_d      = clear ? k_len : klen_q;
        beat_cnt_d  = beat_cnt_q;
        flush_cnt_d = '0;
        row_cnt_d   = '0;
        done_d      = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
        if (clear) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + KLEN_WIDTH'(1);
        end
        if (state_q == ST_FLUSH) begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
        if (state_q == ST_DRAIN) begin
            row_cnt_d = row_cnt_q;
            if (out_ready) begin
                row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            klen_q      <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            row_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            klen_q      <= klen_d;
            beat_cnt_q  <= beat_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            row_cnt_q   <= row_cnt_d;
            done_q      <= done_d;
        end
    end

    // Lane r of A passes through r+1 registers so it reaches PE(r,0) at edge t+1+r.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] sk_q [r+1];
        logic [DATA_WIDTH-1:0] sk_d [r+1];

        always_comb begin
            for (int i = 0; i <= r; i++) sk_d[i] = sk_q[i];
            if (clear) begin
                for (int i = 0; i <= r; i++) sk_d[i] = '0;
            end else if (pe_en) begin
                sk_d[0] = accept ? a_in[lane_lo(r, ROWS, DATA_WIDTH) +: DATA_WIDTH] : '0;
                for (int i = 1; i <= r; i++) sk_d[i] = sk_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) sk_q[i] <= '0;
            end else begin
                for (int i = 0; i <= r; i++) sk_q[i] <= sk_d[i];
            end
        end

        assign a_bus[r][0] = sk_q[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] sk_q [c+1];
        logic [DATA_WIDTH-1:0] sk_d [c+1];

        always_comb begin
            for (int i = 0; i <= c; i++) sk_d[i] = sk_q[i];
            if (clear) begin
                for (int i = 0; i <= c; i++) sk_d[i] = '0;
            end else if (pe_en) begin
                sk_d[0] = accept ? b_in[lane_lo(c, COLS, DATA_WIDTH) +: DATA_WIDTH] : '0;
                for (int i = 1; i <= c; i++) sk_d[i] = sk_q[i-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= c; i++) sk_q[i] <= '0;
            end else begin
                for (int i = 0; i <= c; i++) sk_q[i] <= sk_d[i];
            end
        end

        assign b_bus[0][c] = sk_q[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            mac_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clear(clear),
                .en   (pe_en),
                .a_in (a_bus[r][c]),
                .b_in (b_bus[r][c]),
                .a_out(a_bus[r][c+1]),
                .b_out(b_bus[r+1][c]),
                .acc  (acc_w[r][c])
            );
        end
    end

endmodule

// File: tb/tb_skewed_systolic_array.sv
// Self-checking bench: table of directed and random tiles compared against a
// plain matrix-multiply model, plus reset, backpressure and 16-bit wrap sequences.
module tb_skewed_systolic_array;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int DW    = 8;
    localparam int AW    = 32;
    localparam int WAW   = 16;
    localparam int KW    = 8;
    localparam int MAXK  = 8;
    localparam int NFIX  = 4;
    localparam int NRAND = 6;
    localparam int NVEC  = NFIX + NRAND;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   a_in;
    logic [COLS*DW-1:0]   b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_row;
    logic [COLS*AW-1:0]   out_data;
    logic                 busy;
    logic                 done;

    logic                 w_start;
    logic [KW-1:0]        w_k_len;
    logic                 w_in_valid;
    logic                 w_in_ready;
    logic [ROWS*DW-1:0]   w_a_in;
    logic [COLS*DW-1:0]   w_b_in;
    logic                 w_out_valid;
    logic                 w_out_ready;
    logic                 w_out_row;
    logic [COLS*WAW-1:0]  w_out_data;
    logic                 w_busy;
    logic                 w_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int k;
        int gap;
        int stall;
        int a [ROWS][MAXK];
        int b [MAXK][COLS];
        int exp_c [ROWS][COLS];
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    skewed_systolic_array #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .KLEN_WIDTH(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done)
    );

    skewed_systolic_array #(
        .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(WAW), .KLEN_WIDTH(KW)
    ) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start), .k_len(w_k_len),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .a_in(w_a_in), .b_in(w_b_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_row(w_out_row),
        .out_data(w_out_data), .busy(w_busy), .done(w_done)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane32(input logic [COLS*AW-1:0] d, input int c);
        logic signed [AW-1:0] v;
        v = d[(COLS-c)*AW-1 -: AW];
        return int'(v);
    endfunction

    function automatic int lane16(input logic [COLS*WAW-1:0] d, input int c);
        logic signed [WAW-1:0] v;
        v = d[(COLS-c)*WAW-1 -: WAW];
        return int'(v);
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v.k = 0; v.gap = 0; v.stall = 0;
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < MAXK; j++) v.a[i][j] = 0;
        for (int i = 0; i < MAXK; i++) for (int j = 0; j < COLS; j++) v.b[i][j] = 0;
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) v.exp_c[i][j] = 0;
        return v;
    endfunction

    // Reference: C = A x B over the first k inner-product terms.
    function automatic vec_t model(input vec_t v);
        vec_t m;
        m = v;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                m.exp_c[i][j] = 0;
                for (int kk = 0; kk < v.k; kk++) m.exp_c[i][j] += v.a[i][kk] * v.b[kk][j];
            end
        end
        return m;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start = 1'b1;
        k_len = KW'(v.k);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < v.k; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                a_in = (ROWS*DW)'($urandom);
                b_in = (COLS*DW)'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            a_in = {DW'(v.a[0][i]), DW'(v.a[1][i])};
            b_in = {DW'(v.b[i][0]), DW'(v.b[i][1])};
            chk("in_ready_load", longint'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency_v%0d", idx), lat, (v.k == 0) ? 0 : ROWS + COLS - 1);
        chk($sformatf("busy_drain_v%0d", idx), longint'(busy), 1);
        for (int r = 0; r < ROWS; r++) begin
            for (int s = 0; s <= v.stall; s++) begin
                chk($sformatf("out_valid_v%0d_r%0d", idx, r), longint'(out_valid), 1);
                chk($sformatf("out_row_v%0d_r%0d", idx, r), longint'(out_row), r);
                for (int c = 0; c < COLS; c++) begin
                    chk($sformatf("c_v%0d_r%0d_c%0d", idx, r, c), lane32(out_data, c), v.exp_c[r][c]);
                end
                if (s < v.stall) begin
                    out_ready = 1'b0;
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        chk($sformatf("done_v%0d", idx), longint'(done), 1);
        chk($sformatf("idle_busy_v%0d", idx), longint'(busy), 0);
        chk($sformatf("idle_out_valid_v%0d", idx), longint'(out_valid), 0);
        chk($sformatf("idle_out_data_v%0d", idx), longint'(out_data != '0), 0);
        @(posedge clk); #1;
        chk($sformatf("done_pulse_v%0d", idx), longint'(done), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_in = '0; b_in = '0; out_ready = 1'b0;
        w_start = 1'b0; w_k_len = '0; w_in_valid = 1'b0; w_a_in = '0; w_b_in = '0; w_out_ready = 1'b0;

        v = blank();
        v.k = 2;
        v.a[0][0] = 1; v.a[0][1] = 0; v.a[1][0] = 0; v.a[1][1] = 1;
        v.b[0][0] = 1; v.b[0][1] = 2; v.b[1][0] = 3; v.b[1][1] = 4;
        v.exp_c[0][0] = 1; v.exp_c[0][1] = 2; v.exp_c[1][0] = 3; v.exp_c[1][1] = 4;
        vecs[0] = v;
        v.gap = 3;
        vecs[2] = v;
        v.gap = 0; v.stall = 4;
        vecs[3] = v;
        v = blank();
        v.k = 1;
        v.a[0][0] = -3; v.a[1][0] = 2;
        v.b[0][0] = 4;  v.b[0][1] = -5;
        v.exp_c[0][0] = -12; v.exp_c[0][1] = 15; v.exp_c[1][0] = 8; v.exp_c[1][1] = -10;
        vecs[1] = v;
        for (int n = NFIX; n < NVEC; n++) begin
            v = blank();
            v.k = int'($urandom_range(1, MAXK));
            v.gap = int'($urandom_range(0, 2));
            v.stall = int'($urandom_range(0, 2));
            for (int i = 0; i < ROWS; i++)
                for (int kk = 0; kk < v.k; kk++) v.a[i][kk] = int'($urandom_range(0, 255)) - 128;
            for (int kk = 0; kk < v.k; kk++)
                for (int j = 0; j < COLS; j++) v.b[kk][j] = int'($urandom_range(0, 255)) - 128;
            vecs[n] = model(v);
        end

        @(posedge clk); #1;
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_out_row", longint'(out_row), 0);
        chk("rst_out_data", longint'(out_data != '0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < NVEC; n++) begin
            applyStimulus(vecs[n]);
            checkOutput(vecs[n], n);
        end

        v = blank();
        v.k = 3;
        v.a[0][0] = 5; v.a[1][0] = 7; v.b[0][0] = 9; v.b[0][1] = 11;
        start = 1'b1; k_len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; a_in = {8'd5, 8'd7}; b_in = {8'd9, 8'd11};
        @(posedge clk); #1;
        chk("mid_load_busy", longint'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_done", longint'(done), 0);
        chk("midrst_out_row", longint'(out_row), 0);
        chk("midrst_out_data", longint'(out_data != '0), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        v = blank();
        applyStimulus(v);
        checkOutput(v, 100);

        w_start = 1'b1; w_k_len = 8'd2;
        @(posedge clk); #1;
        w_start = 1'b0;
        w_in_valid = 1'b1; w_a_in = {8'h80, 8'h80}; w_b_in = {8'h80, 8'h80};
        @(posedge clk); #1;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        begin
            int lat;
            lat = 0;
            while (!w_out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("wrap_latency", lat, ROWS + COLS - 1);
        end
        w_out_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) begin
            chk($sformatf("wrap_row_%0d", r), longint'(w_out_row), r);
            for (int c = 0; c < COLS; c++) begin
                chk($sformatf("wrap_r%0d_c%0d", r, c), lane16(w_out_data, c), -32768);
            end
            @(posedge clk); #1;
        end
        w_out_ready = 1'b0;
        chk("wrap_done", longint'(w_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
